// File: rtl/vlc_pkg.sv
// Shared types and helpers for the VLC bit packer.
// Word geometry, packer states and the code-length mask.
package vlc_pkg;

  localparam int WORD_W   = 32;
  localparam int MAX_CODE = 64;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  function automatic logic [MAX_CODE-1:0] mask(input logic [6:0] n);
    if (n >= 7'(MAX_CODE)) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/vlc_word_fifo.sv
// Word FIFO: in-order pair write, single read, registered head.
// free counts a read happening in the same cycle.
module vlc_word_fifo
  import vlc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               wr_n,
  input  logic [WORD_W-1:0]        wr_a,
  input  logic [WORD_W-1:0]        wr_b,
  input  logic                     rd,
  output logic [$clog2(DEPTH):0]   free,
  output logic                     valid,
  output logic [WORD_W-1:0]        head
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rp;
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp_n;
  logic [AW:0]       count;
  logic [AW:0]       cnt_r;
  logic [AW:0]       count_n;
  logic              rd_go;
  logic [WORD_W-1:0] head_n;

  always_comb begin
    rd_go   = rd && valid;
    cnt_r   = count - (AW+1)'(rd_go);
    rp_n    = rp + AW'(rd_go);
    count_n = cnt_r + (AW+1)'(wr_n);
    free    = (AW+1)'(DEPTH) - cnt_r;
    // When nothing older survives the read, the new head is the first write.
    if (cnt_r == '0) head_n = (wr_n != 2'd0) ? wr_a : '0;
    else             head_n = mem[rp_n];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
      valid <= 1'b0;
      head  <= '0;
    end else begin
      rp    <= rp_n;
      wp    <= wp + AW'(wr_n);
      count <= count_n;
      valid <= count_n != '0;
      head  <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_n != 2'd0) mem[wp] <= wr_a;
    if (wr_n == 2'd2) mem[wp + AW'(1)] <= wr_b;
  end

endmodule

// File: rtl/vlc_bit_packer.sv
// Packs 0..64-bit codes MSB-first into 32-bit words with flush padding.
// Completed words go through a small FIFO toward the slice writer.
module vlc_bit_packer
  import vlc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_enable,
  input  logic [63:0]       in_val,
  input  logic [63:0]       in_size,
  input  logic              in_flush,
  output logic              in_busy,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_word,
  input  logic              out_ready,
  output logic              flush_done,
  output logic [31:0]       words_written,
  output logic              overflow_err,
  output logic              size_err
);

  localparam int AW = $clog2(DEPTH);

  state_t      state;
  state_t      state_n;
  // At most 31 bits survive between cycles, so only those are stored.
  logic [30:0] acc;
  logic [4:0]  cnt;

  logic [6:0]  sz;
  logic        size_bad;
  logic        take;
  logic        fits;
  logic [94:0] stream;
  logic [6:0]  total;
  logic [1:0]  k;
  logic [4:0]  rem;
  logic [63:0] words_hi;
  logic [30:0] keep;
  logic [30:0] acc_a;
  logic [4:0]  cnt_a;
  logic [1:0]  nw;
  logic [31:0] pad;

  logic [1:0]  wr_n;
  logic [31:0] wr_a;
  logic [31:0] wr_b;
  logic [30:0] acc_n;
  logic [4:0]  cnt_n;
  logic        done_n;
  logic        ovf_set;
  logic        serr_set;
  logic [AW:0] free;

  vlc_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .wr_n  (wr_n),
    .wr_a  (wr_a),
    .wr_b  (wr_b),
    .rd    (out_ready),
    .free  (free),
    .valid (out_valid),
    .head  (out_word)
  );

  always_comb begin
    sz       = in_size[6:0];
    size_bad = in_enable && ((|in_size[63:7]) || sz > 7'd64);
    take     = state == RUN && in_enable && !size_bad && sz != 7'd0;
    stream   = ({64'b0, acc} << sz) | {31'b0, in_val & mask(sz)};
    total    = {2'b0, cnt} + sz;
    k        = total[6:5];
    rem      = total[4:0];
    words_hi = 64'(stream >> rem);
    fits     = free >= (AW+1)'(k);
    keep     = 31'(mask({2'b0, rem}));

    acc_a = acc;
    cnt_a = cnt;
    nw    = 2'd0;
    if (take && fits) begin
      acc_a = stream[30:0] & keep;
      cnt_a = rem;
      nw    = k;
    end
    pad = {acc_a, 1'b0} << (5'd31 - cnt_a);

    wr_n     = nw;
    wr_a     = (k == 2'd2) ? words_hi[63:32] : words_hi[31:0];
    wr_b     = words_hi[31:0];
    acc_n    = acc_a;
    cnt_n    = cnt_a;
    state_n  = state;
    done_n   = 1'b0;
    ovf_set  = 1'b0;
    serr_set = 1'b0;

    unique case (state)
      RUN: begin
        ovf_set  = take && !fits;
        serr_set = size_bad;
        if (in_flush) begin
          if (cnt_a == 5'd0) begin
            done_n = 1'b1;
          end else if (nw != 2'd2 && free > (AW+1)'(nw)) begin
            if (nw == 2'd0) wr_a = pad;
            else            wr_b = pad;
            wr_n   = nw + 2'd1;
            acc_n  = '0;
            cnt_n  = '0;
            done_n = 1'b1;
          end else begin
            state_n = FLUSH;
          end
        end
      end
      FLUSH: begin
        ovf_set = in_enable;
        if (free != '0) begin
          wr_n    = 2'd1;
          wr_a    = pad;
          acc_n   = '0;
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      acc           <= '0;
      cnt           <= '0;
      flush_done    <= 1'b0;
      words_written <= '0;
      overflow_err  <= 1'b0;
      size_err      <= 1'b0;
    end else begin
      state         <= state_n;
      acc           <= acc_n;
      cnt           <= cnt_n;
      flush_done    <= done_n;
      words_written <= words_written + 32'(wr_n);
      overflow_err  <= overflow_err | ovf_set;
      size_err      <= size_err | serr_set;
    end
  end

  assign in_busy = state == FLUSH;

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Bench for vlc_bit_packer: bit-queue reference model, directed cases
// plus randomized traffic, compared every cycle on the falling edge.
module tb_vlc_bit_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_enable = 1'b0;
  logic [63:0] in_val = '0;
  logic [63:0] in_size = '0;
  logic        in_flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_busy;
  logic        out_valid;
  logic [31:0] out_word;
  logic        flush_done;
  logic [31:0] words_written;
  logic        overflow_err;
  logic        size_err;

  vlc_bit_packer #(.DEPTH(DEPTH)) dut (
    .clock         (clk),
    .reset         (rst),
    .in_enable     (in_enable),
    .in_val        (in_val),
    .in_size       (in_size),
    .in_flush      (in_flush),
    .in_busy       (in_busy),
    .out_valid     (out_valid),
    .out_word      (out_word),
    .out_ready     (out_ready),
    .flush_done    (flush_done),
    .words_written (words_written),
    .overflow_err  (overflow_err),
    .size_err      (size_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: pending bits as a queue, FIFO as a word queue.
  bit          bq[$];
  logic [31:0] mq[$];
  bit          m_busy = 0;
  bit          m_done = 0;
  logic [31:0] m_words = 0;
  bit          m_ovf = 0;
  bit          m_serr = 0;

  function automatic logic [31:0] take_word();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) begin
      w = {w[30:0], 1'b0};
      if (bq.size() > 0) w[0] = bq.pop_front();
    end
    return w;
  endfunction

  function automatic void model_step();
    int nw = 0;
    m_done = 0;
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (!m_busy) begin
      if (in_enable) begin
        if (in_size > 64) begin
          m_serr = 1;
        end else if (in_size != 0) begin
          int tot = bq.size() + int'(in_size);
          int k = tot / 32;
          if (DEPTH - mq.size() >= k) begin
            for (int i = int'(in_size) - 1; i >= 0; i--) bq.push_back(in_val[i]);
            for (int j = 0; j < k; j++) mq.push_back(take_word());
            nw = k;
          end else begin
            m_ovf = 1;
          end
        end
      end
      if (in_flush) begin
        if (bq.size() == 0) m_done = 1;
        else if (nw < 2 && mq.size() < DEPTH) begin
          mq.push_back(take_word());
          nw++;
          m_done = 1;
        end else m_busy = 1;
      end
    end else begin
      if (in_enable) m_ovf = 1;
      if (mq.size() < DEPTH) begin
        mq.push_back(take_word());
        nw++;
        m_done = 1;
        m_busy = 0;
      end
    end
    m_words += 32'(nw);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        bq.delete();
        mq.delete();
        m_busy = 0;
        m_done = 0;
        m_words = 0;
        m_ovf = 0;
        m_serr = 0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        chk("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) chk("out_word", out_word, mq[0]);
        chk("in_busy", in_busy, m_busy);
        chk("flush_done", flush_done, m_done);
        chk("words_written", words_written, m_words);
        chk("overflow_err", overflow_err, m_ovf);
        chk("size_err", size_err, m_serr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic code(input logic [63:0] v, input logic [63:0] s);
    in_enable = 1'b1;
    in_val = v;
    in_size = s;
    tick();
    in_enable = 1'b0;
  endtask

  task automatic flush();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic random_run(input int n, input int ready_pct);
    for (int c = 0; c < n; c++) begin
      int r = $urandom_range(0, 63);
      in_enable = $urandom_range(0, 2) != 0;
      in_val = {$urandom, $urandom};
      if (r == 0) in_size = 64'd0;
      else if (r == 1) in_size = 64'd65 + 64'($urandom_range(0, 60));
      else if (r == 2) in_size = {32'd1, $urandom};
      else if (r < 30) in_size = 64'($urandom_range(1, 8));
      else in_size = 64'($urandom_range(1, 64));
      in_flush = $urandom_range(0, 15) == 0;
      out_ready = $urandom_range(0, 99) < ready_pct;
      tick();
    end
    in_enable = 1'b0;
    in_flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_busy", in_busy, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_words", words_written, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_serr", size_err, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 101 followed by 29 ones
    code(64'h5, 64'd3);
    code(64'h1FFF_FFFF, 64'd29);
    chk("t1_word", out_word, 32'hBFFF_FFFF);
    chk("t1_valid", out_valid, 1);
    chk("t1_words", words_written, 1);
    chk("t1_model_word", mq[0], 32'hBFFF_FFFF);
    chk("t1_model_cnt", bq.size(), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    code(64'h3, 64'd2);
    flush();
    chk("t2_done", flush_done, 1);
    chk("t2_word", out_word, 32'hC000_0000);
    chk("t2_words", words_written, 2);
    tick();
    chk("t2_done_once", flush_done, 0);
    out_ready = 1'b1;
    tick();

    code(64'hFFFF_FFFF_0000_0000, 64'd64);
    chk("t3_word0", out_word, 32'hFFFF_FFFF);
    tick();
    chk("t3_word1", out_word, 32'h0000_0000);
    chk("t3_valid1", out_valid, 1);
    chk("t3_words", words_written, 4);
    tick();
    chk("t3_empty", out_valid, 0);

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) code(64'(i + 1), 64'd32);
    chk("t4_ovf", overflow_err, 1);
    chk("t4_words", words_written, 8);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_drained", out_valid, 0);
    chk("t4_model_acc", bq.size(), 0);
    out_ready = 1'b0;
    flush();
    chk("t4_flush_empty_done", flush_done, 1);
    chk("t4_flush_no_word", words_written, 8);

    do_reset();
    for (int i = 0; i < 4; i++) code(64'(i + 16), 64'd32);
    code(64'h15, 64'd5);
    flush();
    chk("t5_busy", in_busy, 1);
    chk("t5_no_done", flush_done, 0);
    tick();
    chk("t5_hold", in_busy, 1);
    chk("t5_ovf_clear", overflow_err, 0);
    code(64'hABC, 64'd12);
    chk("t5_ovf_busy", overflow_err, 1);
    out_ready = 1'b1;
    tick();
    chk("t5_done", flush_done, 1);
    chk("t5_run", in_busy, 0);
    chk("t5_words", words_written, 5);
    chk("t5_model_pad", mq[mq.size() - 1], 32'hA800_0000);
    for (int i = 0; i < 5; i++) tick();

    code(64'h1, 64'd65);
    chk("t6_serr", size_err, 1);
    chk("t6_words", words_written, 5);

    random_run(1500, 70);
    do_reset();
    random_run(1500, 30);

    out_ready = 1'b0;
    code(64'h1234_5678, 64'd32);
    code(64'h9, 64'd4);
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_word", out_word, 0);
    chk("arst_words", words_written, 0);
    chk("arst_busy", in_busy, 0);
    chk("arst_done", flush_done, 0);
    chk("arst_ovf", overflow_err, 0);
    chk("arst_serr", size_err, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
